operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Front end of the 4-register, 8-bit datapath: fetches instruction words from a synchronous instruction memory, decodes them and reads operands from the register file.
- Hands opcode, in1_val, in2_val and dst_idx to the execute stage over a valid/ready handshake.
- Consumes the execute stage's writeback. A per-register pending scoreboard plus same-cycle forwarding guarantees that operands are never stale.

Parameters:
- PC_W, 8, program counter / instruction address width.
- START_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins fetching from current PC while IDLE.
- imem_addr  out  PC_W  instruction memory address.
- imem_en  out  1  read enable; data is returned on imem_data one cycle later.
- imem_data  in  18  instruction word: [17] imm_sel, [16:13] opcode, [12:11] dst_idx, [10:9] src_idx, [8] halt, [7:0] imm.
- regs  in  32  register file; reg i = regs[8i+7:8i].
- wb_en  in  1  execute stage writes a register this cycle.
- wb_idx  in  2  written register index.
- wb_val  in  8  written value.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  execute stage accepts.
- opcode  out  4  ALU opcode.
- in1_val  out  8  value of regs[dst_idx].
- in2_val  out  8  imm if imm_sel else regs[src_idx].
- dst_idx  out  2  destination register.
- halted  out  1  high once a halt instruction is decoded.
- pc  out  PC_W  current program counter.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, pc=START_PC, pending=4'b0000.
  - out_valid=0, imem_en=0, halted=0.
  - opcode=0, in1_val=0, in2_val=0, dst_idx=0.
  - Reset mid-operation discards any in-flight fetch and any held instruction, with no handshake completing.
- States:
  - IDLE: imem_en=0. On start, go to FETCH.
  - FETCH: imem_en=1, imem_addr=pc; go to WAIT.
  - WAIT: latch imem_data into the instruction register.
    - If halt=1: go to HALT and set halted=1.
    - Otherwise go to ISSUE.
  - ISSUE: out_valid=1 when no hazard.
    - On out_valid&&out_ready: set pending[dst_idx], pc <= pc+1, go to FETCH.
  - HALT: terminal; only reset leaves it. Fields outputs hold their last value; out_valid=0.
- Timing:
  - Minimum issue interval is 3 cycles (FETCH, WAIT, ISSUE).
  - Fetch-to-valid latency is 2 cycles after FETCH.
- Hazard:
  - hazard = pending[dst] || (!imm_sel && pending[src]), evaluated after forwarding.
  - out_valid=0 while hazard is set.
- Forwarding:
  - A wb_en in the same cycle as ISSUE with wb_idx matching a needed register clears the hazard for that register that cycle.
  - The operand output takes wb_val instead of regs.
- Scoreboard:
  - wb_en clears pending[wb_idx].
  - If the issue handshake and a wb_en to the same index occur in the same cycle, set wins: the new instruction is outstanding.
- Operand stability: operand outputs are combinational from the instruction register, regs and forwarding. They must be stable while out_valid=1 and out_ready=0; a wb change while waiting updates them only through forwarding of pending registers.
- Rules:
  - out_valid never deasserts without a handshake once asserted, except on reset.
  - start is ignored outside IDLE.
- PC wraps modulo 2^PC_W (all-ones + 1 = 0). No other boundary action.
- Halt has no side effects: a halt instruction is never issued and does not touch pending.

Test Plan:
- Reset, then start with mem[0]={imm_sel=1, op=2, dst=1, imm=8'h05}, regs reg1=8'h0A, out_ready=1 → out_valid exactly 2 cycles after FETCH; opcode=2, in1_val=8'h0A, in2_val=8'h05, dst_idx=1; pc becomes 1.
- Back-to-back mem[0] writes r1, mem[1] reads r1 as src, wb not yet returned → second instruction holds out_valid=0. Drive wb_en=1, wb_idx=1, wb_val=8'h33 → out_valid=1 in the same cycle with in2_val=8'h33.
- out_ready=0 for 5 cycles while valid → out_valid stays 1, outputs constant, pc unchanged; handshake on cycle 6 advances pc by exactly 1.
- Issue with dst=2 coinciding with wb_en to idx 2 → pending[2] remains set; the next instruction reading r2 stalls until a later wb.
- mem[pc]{halt=1} → halted=1, out_valid never asserts, no further imem_en; start pulses ignored; rst_n=0 returns to IDLE with pc=START_PC.
- PC_W=2, program fills all 4 words with no halt → addresses 0,1,2,3,0 in order. Reset asserted during WAIT → no out_valid, pending cleared.

Source files
------------

// File: rtl/operand_fetch.sv
// Fetch/decode/operand-read front end: FETCH->WAIT->ISSUE (valid 2 cycles after FETCH, 3-cycle issue interval).
// out_valid is held with stable operands until out_ready; pending-register hazards stall issue unless forwarded.
module operand_fetch #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] START_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_en,
   input  logic [17:0]     imem_data,
   input  logic [31:0]     regs,
   input  logic            wb_en,
   input  logic [1:0]      wb_idx,
   input  logic [7:0]      wb_val,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      opcode,
   output logic [7:0]      in1_val,
   output logic [7:0]      in2_val,
   output logic [1:0]      dst_idx,
   output logic            halted,
   output logic [PC_W-1:0] pc
);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_HALT} state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [3:0]      pend_q, pend_d;
   logic [16:0]     ir_q, ir_d;
   logic            ir_vld_q, ir_vld_d;

   logic            ir_imm_sel;
   logic [1:0]      ir_dst, ir_src;
   logic [7:0]      ir_imm, rd_dst, rd_src;
   logic            fwd_dst, fwd_src, hazard, issue_hs;

   // Instruction register keeps every field except the halt bit, which never issues.
   assign ir_imm_sel = ir_q[16];
   assign ir_dst     = ir_q[11:10];
   assign ir_src     = ir_q[9:8];
   assign ir_imm     = ir_q[7:0];
   assign rd_dst     = regs[{ir_dst, 3'b000} +: 8];
   assign rd_src     = regs[{ir_src, 3'b000} +: 8];

   // Only pending registers are forwarded, so a held operand never changes under a stall.
   assign fwd_dst  = wb_en && (wb_idx == ir_dst) && pend_q[ir_dst];
   assign fwd_src  = wb_en && (wb_idx == ir_src) && pend_q[ir_src];
   assign hazard   = (pend_q[ir_dst] && !fwd_dst) ||
                     (!ir_imm_sel && pend_q[ir_src] && !fwd_src);
   assign out_valid = (state_q == S_ISSUE) && !hazard;
   assign issue_hs  = out_valid && out_ready;

   assign opcode    = ir_q[15:12];
   assign dst_idx   = ir_dst;
   assign in1_val   = !ir_vld_q ? 8'h00 : (fwd_dst ? wb_val : rd_dst);
   assign in2_val   = !ir_vld_q ? 8'h00 : ir_imm_sel ? ir_imm : (fwd_src ? wb_val : rd_src);
   assign imem_en   = (state_q == S_FETCH);
   assign imem_addr = pc_q;
   assign halted    = (state_q == S_HALT);
   assign pc        = pc_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      ir_vld_d = ir_vld_q;
      pend_d   = pend_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: state_d = S_WAIT;
         S_WAIT: begin
            if (imem_data[8]) begin
               state_d = S_HALT;
            end else begin
               ir_d     = {imem_data[17:9], imem_data[7:0]};
               ir_vld_d = 1'b1;
               state_d  = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (issue_hs) begin
               pc_d    = pc_q + 1'b1;
               state_d = S_FETCH;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      // Set after clear: an issue colliding with a writeback to the same register stays outstanding.
      if (wb_en)    pend_d[wb_idx] = 1'b0;
      if (issue_hs) pend_d[ir_dst] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         pc_q     <= START_PC;
         pend_q   <= 4'b0000;
         ir_q     <= '0;
         ir_vld_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pend_q   <= pend_d;
         ir_q     <= ir_d;
         ir_vld_q <= ir_vld_d;
      end
   end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed scenarios with literal expectations plus randomized traffic against a cycle model.
module tb_operand_fetch;
   localparam int PC_W = 2;

   logic            clk = 1'b0;
   logic            rst_n, start, imem_en, wb_en, out_valid, out_ready, halted;
   logic [PC_W-1:0] imem_addr, pc;
   logic [17:0]     imem_data;
   logic [31:0]     regs;
   logic [1:0]      wb_idx, dst_idx;
   logic [7:0]      wb_val, in1_val, in2_val;
   logic [3:0]      opcode;

   always #5 clk = ~clk;

   operand_fetch #(.PC_W(PC_W), .START_PC(2'd0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
      .regs(regs), .wb_en(wb_en), .wb_idx(wb_idx), .wb_val(wb_val),
      .out_valid(out_valid), .out_ready(out_ready),
      .opcode(opcode), .in1_val(in1_val), .in2_val(in2_val), .dst_idx(dst_idx),
      .halted(halted), .pc(pc)
   );

   logic [17:0] mem [0:3];
   always @(posedge clk) if (imem_en) imem_data <= mem[imem_addr];

   int n_tests = 0;
   int n_fail  = 0;

   // Model: mode 0 idle, 1 running, 2 halted; cnt counts cycles since the fetch.
   int              m_mode, m_cnt;
   logic [PC_W-1:0] m_pc;
   logic [3:0]      m_pend;
   logic [17:0]     m_ir;
   logic [7:0]      regs_m [4];
   logic            m_hs;
   logic [1:0]      m_hs_dst;

   logic       d_rst_n, d_start, d_ready, d_wb_en;
   logic [1:0] d_wb_idx;
   logic [7:0] d_wb_val;

   logic            s_valid, s_en, s_halted;
   logic [PC_W-1:0] s_addr, s_pc;
   logic [3:0]      s_op;
   logic [7:0]      s_in1, s_in2;
   logic [1:0]      s_dst;

   int  ex_out [4];
   int  ex_due [4];
   int  halt_cycles;

   function automatic logic [17:0] ins(input logic isel, input logic [3:0] op, input logic [1:0] dst,
                                       input logic [1:0] src, input logic hlt, input logic [7:0] imm);
      return {isel, op, dst, src, hlt, imm};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      logic [1:0] dd, ss;
      logic       isel, hz, e_valid, e_en;
      logic [7:0] e_in1, e_in2;
      @(negedge clk);
      rst_n     = d_rst_n;
      start     = d_start;
      out_ready = d_ready;
      wb_en     = d_wb_en;
      wb_idx    = d_wb_idx;
      wb_val    = d_wb_val;
      regs      = {regs_m[3], regs_m[2], regs_m[1], regs_m[0]};
      #1;
      s_valid = out_valid; s_en = imem_en; s_halted = halted; s_addr = imem_addr; s_pc = pc;
      s_op = opcode; s_in1 = in1_val; s_in2 = in2_val; s_dst = dst_idx;
      m_hs = 1'b0;
      if (d_rst_n) begin
         dd   = m_ir[12:11];
         ss   = m_ir[10:9];
         isel = m_ir[17];
         hz   = (m_pend[dd] && !(d_wb_en && d_wb_idx == dd)) ||
                (!isel && m_pend[ss] && !(d_wb_en && d_wb_idx == ss));
         e_valid = (m_mode == 1) && (m_cnt >= 2) && !hz;
         e_en    = (m_mode == 1) && (m_cnt == 0);
         e_in1   = (d_wb_en && d_wb_idx == dd && m_pend[dd]) ? d_wb_val : regs_m[dd];
         e_in2   = isel ? m_ir[7:0] :
                   (d_wb_en && d_wb_idx == ss && m_pend[ss]) ? d_wb_val : regs_m[ss];
         chk("out_valid", 32'(s_valid), 32'(e_valid));
         chk("imem_en", 32'(s_en), 32'(e_en));
         if (e_en) chk("imem_addr", 32'(s_addr), 32'(m_pc));
         chk("halted", 32'(s_halted), 32'(m_mode == 2));
         chk("pc", 32'(s_pc), 32'(m_pc));
         if (e_valid) begin
            chk("opcode", 32'(s_op), 32'(m_ir[16:13]));
            chk("dst_idx", 32'(s_dst), 32'(dd));
            chk("in1_val", 32'(s_in1), 32'(e_in1));
            chk("in2_val", 32'(s_in2), 32'(e_in2));
         end
         m_hs     = e_valid && d_ready;
         m_hs_dst = dd;
         if (d_wb_en) m_pend[d_wb_idx] = 1'b0;
         if (m_hs)    m_pend[dd] = 1'b1;
         if (m_mode == 0) begin
            if (d_start) begin m_mode = 1; m_cnt = 0; end
         end else if (m_mode == 1) begin
            if (m_cnt == 0) m_cnt = 1;
            else if (m_cnt == 1) begin
               if (mem[m_pc][8]) m_mode = 2;
               else begin m_ir = mem[m_pc]; m_cnt = 2; end
            end else if (m_hs) begin
               m_pc  = m_pc + 1'b1;
               m_cnt = 0;
            end else m_cnt++;
         end
      end else begin
         m_mode = 0; m_cnt = 0; m_pc = '0; m_pend = 4'b0000; m_ir = '0;
      end
      if (d_wb_en) regs_m[d_wb_idx] = d_wb_val;
   endtask

   task automatic idle_in();
      d_rst_n = 1'b1; d_start = 1'b0; d_ready = 1'b1; d_wb_en = 1'b0; d_wb_idx = 2'd0; d_wb_val = 8'h00;
   endtask

   task automatic do_reset();
      d_rst_n = 1'b0; step(); d_rst_n = 1'b1;
   endtask

   task automatic pulse_start();
      d_start = 1'b1; step(); d_start = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rand_mem();
      for (int i = 0; i < 4; i++)
         mem[i] = ins(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] h_in1, h_in2;
      logic [3:0] h_op;
      int         nfetch;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; wb_en = 1'b0; wb_idx = 2'd0; wb_val = 8'h00;
      regs = '0; imem_data = '0;
      for (int i = 0; i < 4; i++) begin
         regs_m[i] = 8'hA0 + 8'(i);
         mem[i]    = '0;
         ex_out[i] = 0;
         ex_due[i] = 0;
      end
      idle_in();
      do_reset();

      // Reset state, with non-zero register file to show operands are gated.
      step();
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_en", 32'(s_en), 32'd0);
      chk("rst_halted", 32'(s_halted), 32'd0);
      chk("rst_opcode", 32'(s_op), 32'd0);
      chk("rst_in1", 32'(s_in1), 32'd0);
      chk("rst_in2", 32'(s_in2), 32'd0);
      chk("rst_dst", 32'(s_dst), 32'd0);
      chk("rst_pc", 32'(s_pc), 32'd0);

      // Single immediate instruction, then halt behaviour.
      mem[0] = ins(1'b1, 4'd2, 2'd1, 2'd0, 1'b0, 8'h05);
      mem[1] = ins(1'b0, 4'd0, 2'd0, 2'd0, 1'b1, 8'h00);
      regs_m[1] = 8'h0A;
      pulse_start();
      step();
      chk("t1_fetch_en", 32'(s_en), 32'd1);
      chk("t1_fetch_addr", 32'(s_addr), 32'd0);
      step();
      chk("t1_wait_valid", 32'(s_valid), 32'd0);
      step();
      chk("t1_valid", 32'(s_valid), 32'd1);
      chk("t1_opcode", 32'(s_op), 32'd2);
      chk("t1_in1", 32'(s_in1), 32'h0A);
      chk("t1_in2", 32'(s_in2), 32'h05);
      chk("t1_dst", 32'(s_dst), 32'd1);
      step();
      chk("t1_pc_after", 32'(s_pc), 32'd1);
      steps(2);
      chk("halt_set", 32'(s_halted), 32'd1);
      for (int i = 0; i < 6; i++) begin
         d_start = 1'(i % 2);
         step();
         chk("halt_no_en", 32'(s_en), 32'd0);
         chk("halt_no_valid", 32'(s_valid), 32'd0);
      end
      d_start = 1'b0;
      do_reset();
      step();
      chk("halt_rst_halted", 32'(s_halted), 32'd0);
      chk("halt_rst_pc", 32'(s_pc), 32'd0);

      // RAW stall on a pending source, released by a forwarded writeback.
      mem[0] = ins(1'b1, 4'd3, 2'd1, 2'd0, 1'b0, 8'h07);
      mem[1] = ins(1'b0, 4'd1, 2'd0, 2'd1, 1'b0, 8'h00);
      mem[2] = ins(1'b0, 4'd0, 2'd0, 2'd0, 1'b1, 8'h00);
      pulse_start();
      steps(3);
      chk("t2_first_valid", 32'(s_valid), 32'd1);
      steps(2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_stall", 32'(s_valid), 32'd0);
      end
      d_wb_en = 1'b1; d_wb_idx = 2'd1; d_wb_val = 8'h33;
      step();
      d_wb_en = 1'b0;
      chk("t2_fwd_valid", 32'(s_valid), 32'd1);
      chk("t2_fwd_in2", 32'(s_in2), 32'h33);
      steps(4);
      do_reset();

      // Backpressure: operands and pc hold until the handshake.
      mem[0] = ins(1'b1, 4'd4, 2'd2, 2'd0, 1'b0, 8'h5A);
      mem[1] = ins(1'b0, 4'd0, 2'd0, 2'd0, 1'b1, 8'h00);
      d_ready = 1'b0;
      pulse_start();
      steps(3);
      chk("t3_valid", 32'(s_valid), 32'd1);
      h_op = s_op; h_in1 = s_in1; h_in2 = s_in2;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t3_hold_valid", 32'(s_valid), 32'd1);
         chk("t3_hold_op", 32'(s_op), 32'(h_op));
         chk("t3_hold_in1", 32'(s_in1), 32'(h_in1));
         chk("t3_hold_in2", 32'(s_in2), 32'h5A);
         chk("t3_hold_pc", 32'(s_pc), 32'd0);
      end
      d_ready = 1'b1;
      step();
      chk("t3_hs_valid", 32'(s_valid), 32'd1);
      step();
      chk("t3_pc_plus1", 32'(s_pc), 32'd1);
      steps(3);
      do_reset();

      // Issue colliding with writeback to the same register: pending stays set.
      mem[0] = ins(1'b1, 4'd5, 2'd2, 2'd0, 1'b0, 8'h01);
      mem[1] = ins(1'b1, 4'd6, 2'd2, 2'd0, 1'b0, 8'h02);
      mem[2] = ins(1'b0, 4'd7, 2'd0, 2'd2, 1'b0, 8'h00);
      mem[3] = ins(1'b0, 4'd0, 2'd0, 2'd0, 1'b1, 8'h00);
      pulse_start();
      steps(3);
      chk("t4_first_valid", 32'(s_valid), 32'd1);
      steps(3);
      chk("t4_dst_stall", 32'(s_valid), 32'd0);
      d_wb_en = 1'b1; d_wb_idx = 2'd2; d_wb_val = 8'h44;
      step();
      d_wb_en = 1'b0;
      chk("t4_fwd_valid", 32'(s_valid), 32'd1);
      chk("t4_fwd_in1", 32'(s_in1), 32'h44);
      steps(2);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t4_src_stall", 32'(s_valid), 32'd0);
      end
      d_wb_en = 1'b1; d_wb_idx = 2'd2; d_wb_val = 8'h55;
      step();
      d_wb_en = 1'b0;
      chk("t4_late_valid", 32'(s_valid), 32'd1);
      chk("t4_late_in2", 32'(s_in2), 32'h55);
      steps(4);
      do_reset();

      // PC wrap with PC_W=2, then reset during WAIT.
      for (int i = 0; i < 4; i++) mem[i] = ins(1'b1, 4'(i), 2'(i), 2'd0, 1'b0, 8'(i));
      pulse_start();
      nfetch = 0;
      for (int i = 0; i < 30 && nfetch < 5; i++) begin
         step();
         if (s_en) begin
            chk("wrap_addr", 32'(s_addr), 32'(nfetch % 4));
            nfetch++;
         end
      end
      chk("wrap_fetch_count", 32'(nfetch), 32'd5);
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step();
         chk("wrst_valid", 32'(s_valid), 32'd0);
         chk("wrst_en", 32'(s_en), 32'd0);
      end
      pulse_start();
      steps(3);
      chk("wrst_pend_clear", 32'(s_valid), 32'd1);
      chk("wrst_pc", 32'(s_pc), 32'd0);
      do_reset();

      // Randomized traffic with a variable-latency execute stage.
      rand_mem();
      halt_cycles = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int r0;
         idle_in();
         d_rst_n = ($urandom_range(0, 299) != 0);
         if (m_mode == 2) begin
            halt_cycles++;
            if (halt_cycles > 3) d_rst_n = 1'b0;
         end
         d_start = ($urandom_range(0, 3) == 0);
         d_ready = ($urandom_range(0, 9) < 7);
         r0 = int'($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) begin
            int r;
            r = (r0 + k) % 4;
            if (!d_wb_en && ex_out[r] != 0 && ex_due[r] == 0 && $urandom_range(0, 1) == 1) begin
               d_wb_en  = 1'b1;
               d_wb_idx = 2'(r);
               d_wb_val = 8'($urandom_range(0, 255));
            end
         end
         step();
         for (int r = 0; r < 4; r++) if (ex_due[r] > 0) ex_due[r]--;
         if (d_wb_en) ex_out[d_wb_idx] = 0;
         if (m_hs) begin
            ex_out[m_hs_dst] = 1;
            ex_due[m_hs_dst] = int'($urandom_range(0, 6));
         end
         if (!d_rst_n) begin
            for (int r = 0; r < 4; r++) ex_out[r] = 0;
            halt_cycles = 0;
            rand_mem();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
